// File: rtl/uartwb_burst_control.sv
// Host-command controller: parses framed UART commands, runs single/burst Wishbone
// accesses through the wrapper, and answers each frame with a status-terminated response.
module uartwb_burst_control #(
  parameter int unsigned ADDR_WID    = 32,
  parameter int unsigned DATA_WID    = 32,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                uartrx_valid_i,
  input  logic [7:0]          uartrx_data_i,
  input  logic                uarttx_ready_i,
  output logic                uarttx_en_o,
  output logic [7:0]          uarttx_data_o,
  output logic                wrapper_wr_o,
  output logic                wrapper_en_o,
  input  logic                wrapper_valid_i,
  input  logic                wrapper_err_i,
  output logic [ADDR_WID-1:0] wrapper_addr_o,
  output logic [DATA_WID-1:0] wrapper_data_o,
  input  logic [DATA_WID-1:0] wrapper_data_i
);

  localparam int unsigned AddrBytes = ADDR_WID / 8;
  localparam int unsigned DataBytes = DATA_WID / 8;
  localparam int unsigned TimerW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] StatOk       = 8'h00;
  localparam logic [7:0] StatBusErr   = 8'h01;
  localparam logic [7:0] StatBusTo    = 8'h02;
  localparam logic [7:0] StatBadFrame = 8'h03;
  localparam logic [7:0] StatRxTo     = 8'h04;

  typedef enum logic [3:0] {
    StIdle, StRxCnt, StRxAddr, StRxData, StWbReq, StWbWait, StTxCmd, StTxData, StTxStat
  } state_e;

  state_e              state_q;
  logic                rx_valid_q;
  logic [7:0]          cmd_q;
  logic [7:0]          cnt_q;
  logic [7:0]          word_idx_q;
  logic [7:0]          status_q;
  logic [3:0]          byte_idx_q;
  logic [ADDR_WID-1:0] addr_q;
  logic [DATA_WID-1:0] wdata_q;
  logic [DATA_WID-1:0] rdata_q;
  logic [TimerW-1:0]   timer_q;
  logic                wb_en_q;
  logic                wb_wr_q;
  logic [ADDR_WID-1:0] wb_addr_q;
  logic [DATA_WID-1:0] wb_data_q;

  logic                byte_stb;
  logic                timer_expired;
  logic                last_word;
  logic                last_addr_byte;
  logic                last_data_byte;
  logic [ADDR_WID-1:0] next_addr;

  assign byte_stb       = uartrx_valid_i & ~rx_valid_q;
  assign timer_expired  = (timer_q == TimerW'(TIMEOUT_CYC - 1));
  assign last_word      = (word_idx_q == cnt_q);
  assign last_addr_byte = (byte_idx_q == 4'(AddrBytes - 1));
  assign last_data_byte = (byte_idx_q == 4'(DataBytes - 1));
  assign next_addr      = cmd_q[2] ? addr_q : addr_q + ADDR_WID'(DataBytes);

  assign wrapper_en_o   = wb_en_q;
  assign wrapper_wr_o   = wb_wr_q;
  assign wrapper_addr_o = wb_addr_q;
  assign wrapper_data_o = wb_data_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= StIdle;
      rx_valid_q <= 1'b1;
      cmd_q      <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      status_q   <= StatOk;
      byte_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      rx_valid_q <= uartrx_valid_i;
      wb_en_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (byte_stb) begin
            cmd_q      <= uartrx_data_i;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            status_q   <= StatOk;
            if (|uartrx_data_i[7:3]) begin
              status_q <= StatBadFrame;
              state_q  <= StTxCmd;
            end else if (uartrx_data_i[1]) begin
              state_q <= StRxCnt;
            end else begin
              state_q <= StRxAddr;
            end
          end
        end
        StRxCnt: begin
          if (byte_stb) begin
            timer_q <= '0;
            cnt_q   <= uartrx_data_i;
            if (32'(uartrx_data_i) >= MAX_BURST) begin
              status_q <= StatBadFrame;
              state_q  <= StTxCmd;
            end else begin
              state_q <= StRxAddr;
            end
          end else if (timer_expired) begin
            status_q <= StatRxTo;
            state_q  <= StTxCmd;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRxAddr: begin
          if (byte_stb) begin
            timer_q <= '0;
            addr_q  <= ADDR_WID'({addr_q, uartrx_data_i});
            if (last_addr_byte) begin
              byte_idx_q <= '0;
              state_q    <= cmd_q[0] ? StRxData : StTxCmd;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else if (timer_expired) begin
            status_q <= StatRxTo;
            state_q  <= StTxCmd;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRxData: begin
          if (byte_stb) begin
            timer_q <= '0;
            wdata_q <= DATA_WID'({wdata_q, uartrx_data_i});
            if (last_data_byte) begin
              byte_idx_q <= '0;
              if (status_q == StatOk) begin
                state_q <= StWbReq;
              end else if (last_word) begin
                // Word received only to keep the frame in step; no bus access after an error.
                state_q <= StTxCmd;
              end else begin
                word_idx_q <= word_idx_q + 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else if (timer_expired) begin
            if (status_q == StatOk) status_q <= StatRxTo;
            state_q <= StTxCmd;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StWbReq: begin
          wb_en_q   <= 1'b1;
          wb_wr_q   <= cmd_q[0];
          wb_addr_q <= addr_q;
          wb_data_q <= wdata_q;
          timer_q   <= '0;
          state_q   <= StWbWait;
        end
        StWbWait: begin
          if (wrapper_valid_i || timer_expired) begin
            addr_q <= next_addr;
            if (wrapper_valid_i && !wrapper_err_i) begin
              rdata_q <= wrapper_data_i;
            end else begin
              rdata_q  <= '0;
              status_q <= wrapper_valid_i ? StatBusErr : StatBusTo;
            end
            if (!cmd_q[0]) begin
              state_q <= StTxData;
            end else if (last_word) begin
              state_q <= StTxCmd;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
              timer_q    <= '0;
              state_q    <= StRxData;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StTxCmd: begin
          if (uarttx_ready_i) begin
            state_q <= (!cmd_q[0] && status_q == StatOk) ? StWbReq : StTxStat;
          end
        end
        StTxData: begin
          if (uarttx_ready_i) begin
            // Shifting out leaves rdata_q zero, so words after an error go out as 0x00.
            rdata_q <= rdata_q << 8;
            if (last_data_byte) begin
              byte_idx_q <= '0;
              if (last_word) begin
                state_q <= StTxStat;
              end else begin
                word_idx_q <= word_idx_q + 1'b1;
                state_q    <= (status_q == StatOk) ? StWbReq : StTxData;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        StTxStat: begin
          if (uarttx_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    uarttx_en_o   = 1'b0;
    uarttx_data_o = 8'h00;
    case (state_q)
      StTxCmd: begin
        uarttx_en_o   = uarttx_ready_i;
        uarttx_data_o = cmd_q;
      end
      StTxData: begin
        uarttx_en_o   = uarttx_ready_i;
        uarttx_data_o = rdata_q[DATA_WID-1 -: 8];
      end
      StTxStat: begin
        uarttx_en_o   = uarttx_ready_i;
        uarttx_data_o = status_q;
      end
      default: ;
    endcase
  end

endmodule
